house_sorter: RTL and testbench

HOUSE_SORTER -- requirements
Module: house_sorter

---
 rtl/house_pkg.sv | 32 +++
 rtl/lfsr8.sv | 25 ++
 rtl/house_sorter.sv | 160 ++++++++++++++++
 tb/tb_house_sorter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/house_pkg.sv
// Shared definitions for the sorting-hat block: house codes, FSM states, LFSR seed, timeout.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package house_pkg;

    typedef enum logic [1:0] {
        GRYF  = 2'b00,
        SLYTH = 2'b01,
        RAVEN = 2'b10,
        HUFF  = 2'b11
    } house_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PICK1  = 3'd1,
        PICK2  = 3'd2,
        PLAY   = 3'd3,
        LEADER = 3'd4
    } state_t;

    localparam logic [7:0] LFSR_SEED       = 8'hA5;
    localparam int         DEFAULT_TIMEOUT = 50000000;

    // Bit index of the result equals the house code: {H, R, S, G}.
    function automatic logic [3:0] house_onehot(input house_t h);
        logic [3:0] oh;
        oh    = 4'b0000;
        oh[h] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, used as the hat's random source.
// Latency: new value every cycle.
// Backpressure: none; never stalls.
module lfsr8
    import house_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    output logic [7:0] q
);

    logic fb;

    // Maximal-length polynomial from a nonzero seed never reaches the all-zero lock-up state.
    assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[6:0], fb};
        end
    end

endmodule

// File: rtl/house_sorter.sv
// Sorting ceremony FSM: two players pick houses (manually or by hat timeout), play, then show the winner.
// Latency: all outputs registered, one cycle after the causing input.
// Backpressure: none; single-cycle input pulses are consumed or ignored.
module house_sorter
    import house_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
)
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       btn_next,
    input  logic       btn_confirm,
    input  logic       turn_end,
    input  logic       game_over,
    input  logic [7:0] score1,
    input  logic [7:0] score2,
    output logic       G1, S1, R1, H1,
    output logic       G2, S2, R2, H2,
    output logic       Gl, Sl, Rl, Hl,
    output logic       player,
    output logic       leaderboard
);

    localparam int              TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_n;
    house_t        cursor, cursor_n;
    house_t        house1, house1_n, house2, house2_n, win_house, win_n;
    logic          lock1, lock1_n, lock2, lock2_n;
    logic          player_q, player_n;
    logic [TW-1:0] timer, timer_n;
    logic [3:0]    p1_flags, p1_flags_n, p2_flags, p2_flags_n, win_flags, win_flags_n;
    logic          lb_q, lb_n;
    logic          pick_lock;
    house_t        pick_house;
    logic [7:0]    lfsr_q;
    logic [5:0]    lfsr_unused;

    lfsr8 u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .q      (lfsr_q)
    );

    assign lfsr_unused = lfsr_q[7:2];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cursor    <= GRYF;
            timer     <= '0;
            house1    <= GRYF;
            house2    <= GRYF;
            win_house <= GRYF;
            lock1     <= 1'b0;
            lock2     <= 1'b0;
            player_q  <= 1'b0;
            p1_flags  <= 4'b0000;
            p2_flags  <= 4'b0000;
            win_flags <= 4'b0000;
            lb_q      <= 1'b0;
        end else begin
            state     <= state_n;
            cursor    <= cursor_n;
            timer     <= timer_n;
            house1    <= house1_n;
            house2    <= house2_n;
            win_house <= win_n;
            lock1     <= lock1_n;
            lock2     <= lock2_n;
            player_q  <= player_n;
            p1_flags  <= p1_flags_n;
            p2_flags  <= p2_flags_n;
            win_flags <= win_flags_n;
            lb_q      <= lb_n;
        end
    end

    always_comb begin
        state_n    = state;
        cursor_n   = cursor;
        timer_n    = timer;
        house1_n   = house1;
        house2_n   = house2;
        win_n      = win_house;
        lock1_n    = lock1;
        lock2_n    = lock2;
        player_n   = player_q;
        pick_lock  = 1'b0;
        pick_house = cursor;

        case (state)
            IDLE, LEADER: begin
                if (start) begin
                    state_n  = PICK1;
                    cursor_n = GRYF;
                    timer_n  = '0;
                    house1_n = GRYF;
                    house2_n = GRYF;
                    win_n    = GRYF;
                    lock1_n  = 1'b0;
                    lock2_n  = 1'b0;
                    player_n = 1'b0;
                end
            end
            PICK1, PICK2: begin
                // Confirm locks the pre-increment cursor and beats a simultaneous timeout.
                pick_lock  = btn_confirm || (timer == TIMER_LAST);
                pick_house = btn_confirm ? cursor : house_t'(lfsr_q[1:0]);
                if (pick_lock) begin
                    cursor_n = GRYF;
                    timer_n  = '0;
                    if (state == PICK1) begin
                        house1_n = pick_house;
                        lock1_n  = 1'b1;
                        state_n  = PICK2;
                        player_n = 1'b1;
                    end else begin
                        house2_n = pick_house;
                        lock2_n  = 1'b1;
                        state_n  = PLAY;
                        player_n = 1'b0;
                    end
                end else if (btn_next) begin
                    cursor_n = house_t'(cursor + 2'd1);
                    timer_n  = '0;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            PLAY: begin
                if (game_over) begin
                    state_n = LEADER;
                    win_n   = (score1 >= score2) ? house1 : house2;
                end else if (turn_end) begin
                    player_n = ~player_q;
                end
            end
            default: state_n = IDLE;
        endcase

        // Flags are derived from next-state values so they register alongside the state.
        p1_flags_n  = (state_n == PICK1) ? house_onehot(cursor_n) :
                      (lock1_n ? house_onehot(house1_n) : 4'b0000);
        p2_flags_n  = (state_n == PICK2) ? house_onehot(cursor_n) :
                      (lock2_n ? house_onehot(house2_n) : 4'b0000);
        win_flags_n = (state_n == LEADER) ? house_onehot(win_n) : 4'b0000;
        lb_n        = (state_n == LEADER);
    end

    assign {H1, R1, S1, G1} = p1_flags;
    assign {H2, R2, S2, G2} = p2_flags;
    assign {Hl, Rl, Sl, Gl} = win_flags;
    assign player           = player_q;
    assign leaderboard      = lb_q;

endmodule

// File: tb/tb_house_sorter.sv
// Directed bench for house_sorter with a short hat timeout and an independent LFSR reference.
module tb_house_sorter;
    import house_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0, btn_next = 1'b0, btn_confirm = 1'b0;
    logic       turn_end = 1'b0, game_over = 1'b0;
    logic [7:0] score1 = 8'd0, score2 = 8'd0;
    logic       G1, S1, R1, H1, G2, S2, R2, H2, Gl, Sl, Rl, Hl;
    logic       player, leaderboard;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] lfsr_m;
    logic [1:0] exp_house;
    logic [3:0] exp_oh;

    house_sorter #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .btn_next    (btn_next),
        .btn_confirm (btn_confirm),
        .turn_end    (turn_end),
        .game_over   (game_over),
        .score1      (score1),
        .score2      (score2),
        .G1(G1), .S1(S1), .R1(R1), .H1(H1),
        .G2(G2), .S2(S2), .R2(R2), .H2(H2),
        .Gl(Gl), .Sl(Sl), .Rl(Rl), .Hl(Hl),
        .player      (player),
        .leaderboard (leaderboard)
    );

    always #5 clk = ~clk;

    // Reference LFSR: taps 8,6,5,4 -> feedback from bits 7,5,4,3 (mask 8'hB8).
    always @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_m <= 8'hA5;
        else         lfsr_m <= {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
    end

    wire [3:0] p1 = {H1, R1, S1, G1};
    wire [3:0] p2 = {H2, R2, S2, G2};
    wire [3:0] pw = {Hl, Rl, Sl, Gl};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();    start = 1'b1;       tick(); start = 1'b0;       endtask
    task automatic do_next();     btn_next = 1'b1;    tick(); btn_next = 1'b0;    endtask
    task automatic do_confirm();  btn_confirm = 1'b1; tick(); btn_confirm = 1'b0; endtask
    task automatic do_turn();     turn_end = 1'b1;    tick(); turn_end = 1'b0;    endtask
    task automatic do_over();     game_over = 1'b1;   tick(); game_over = 1'b0;   endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_p1", 32'(p1), 32'h0);
        check("rst_p2", 32'(p2), 32'h0);
        check("rst_win", 32'(pw), 32'h0);
        check("rst_player", 32'(player), 32'h0);
        check("rst_lb", 32'(leaderboard), 32'h0);
        check("rst_lfsr", 32'(dut.u_lfsr.q), 32'hA5);
        resetn = 1'b1;
        tick();

        // Full manual ceremony: P1 Ravenclaw, P2 Slytherin
        do_start();
        check("start_state", 32'(dut.state), 32'(PICK1));
        check("start_preview", 32'(p1), 32'b0001);
        do_next();
        do_next();
        check("p1_preview_r", 32'(p1), 32'b0100);
        do_confirm();
        check("pick2_state", 32'(dut.state), 32'(PICK2));
        check("p1_locked_r", 32'(p1), 32'b0100);
        check("p2_preview_g", 32'(p2), 32'b0001);
        check("pick2_player", 32'(player), 32'h1);
        do_next(); do_next(); do_next(); do_next();
        check("cursor_wrap", 32'(p2), 32'b0001);
        do_next();
        check("p2_preview_s", 32'(p2), 32'b0010);
        do_confirm();
        check("play_state", 32'(dut.state), 32'(PLAY));
        check("play_p1", 32'(p1), 32'b0100);
        check("play_p2", 32'(p2), 32'b0010);
        check("play_player", 32'(player), 32'h0);

        // Turns, then reset in the middle of play
        do_turn();
        check("turn1_player", 32'(player), 32'h1);
        do_turn();
        do_turn();
        check("turn3_player", 32'(player), 32'h1);
        resetn = 1'b0;
        #1;
        check("mid_rst_p1", 32'(p1), 32'h0);
        check("mid_rst_p2", 32'(p2), 32'h0);
        check("mid_rst_player", 32'(player), 32'h0);
        check("mid_rst_lb", 32'(leaderboard), 32'h0);
        check("mid_rst_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check("post_rst_p1", 32'(p1), 32'h0);

        // Next and confirm in the same cycle lock the pre-increment cursor
        do_start();
        btn_next = 1'b1; btn_confirm = 1'b1;
        tick();
        btn_next = 1'b0; btn_confirm = 1'b0;
        check("same_cyc_p1", 32'(p1), 32'b0001);
        check("same_cyc_state", 32'(dut.state), 32'(PICK2));
        check("same_cyc_cursor", 32'(dut.cursor), 32'(GRYF));
        do_over();
        check("over_ignored", 32'(dut.state), 32'(PICK2));
        check("over_ignored_lb", 32'(leaderboard), 32'h0);
        do_next();
        do_confirm();
        do_start();
        check("start_ignored", 32'(dut.state), 32'(PLAY));
        score1 = 8'd3; score2 = 8'd9;
        do_over();
        check("p2_wins_s", 32'(pw), 32'b0010);
        check("leader_lb", 32'(leaderboard), 32'h1);
        check("leader_p1", 32'(p1), 32'b0001);

        // Restart from leaderboard
        do_start();
        check("restart_state", 32'(dut.state), 32'(PICK1));
        check("restart_win", 32'(pw), 32'h0);
        check("restart_p2", 32'(p2), 32'h0);
        check("restart_p1", 32'(p1), 32'b0001);
        check("restart_lb", 32'(leaderboard), 32'h0);

        // P1 Hufflepuff vs P2 Gryffindor, tie goes to P1
        do_next(); do_next(); do_next();
        do_confirm();
        do_confirm();
        check("hg_p1", 32'(p1), 32'b1000);
        check("hg_p2", 32'(p2), 32'b0001);
        do_turn();
        score1 = 8'd40; score2 = 8'd40;
        do_over();
        check("tie_win_h", 32'(pw), 32'b1000);
        check("tie_lb", 32'(leaderboard), 32'h1);
        check("tie_player_hold", 32'(player), 32'h1);
        do_start();
        do_next(); do_next(); do_next();
        do_confirm();
        do_confirm();
        score2 = 8'd41;
        do_over();
        check("p2_win_g", 32'(pw), 32'b0001);
        check("p2_win_player", 32'(player), 32'h0);

        // Hat timeout: 16 idle cycles in PICK1 lock the LFSR house
        do_start();
        repeat (15) tick();
        check("pre_timeout_state", 32'(dut.state), 32'(PICK1));
        exp_house = lfsr_m[1:0];
        exp_oh = 4'b0001 << exp_house;
        tick();
        check("timeout_state", 32'(dut.state), 32'(PICK2));
        check("timeout_p1", 32'(p1), 32'(exp_oh));
        check("timeout_p2_preview", 32'(p2), 32'b0001);
        check("timeout_player", 32'(player), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
